// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package ram_pkg;

  // Clear-sweep sequencer states.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // Same-address read-during-write result selection.
  localparam int RDW_OLD = 0;  // read returns the pre-write contents
  localparam int RDW_NEW = 1;  // read returns the data being written

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps INIT_VAL over every entry after reset or a clr pulse.
// While the sweep runs it owns the array write port (clr_we/clr_addr) and
// holds busy high; it terminates after writing entry DEPTH-1.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output ram_state_e       state
);

  // The pointer is one bit wider than the address so DEPTH == 2**ADDR_W
  // reaches its last entry without wrapping.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  ram_state_e      r_state;
  logic [ADDR_W:0] r_ptr;
  logic            r_busy;

  // Sweep FSM: walk the pointer through the array, restart on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (clr) begin
            // A new request during the sweep starts it over from entry 0.
            r_ptr <= '0;
          end else if (r_ptr == LAST_PTR) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + PTR_ONE;
          end
        end
        ST_READY: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign clr_we   = (r_state == ST_CLEAR);
  assign clr_addr = r_ptr[IDX_W-1:0];
  assign state    = r_state;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port RAM: one write port, one registered read port,
// hardware clear sweep, selectable read-during-write result and an optional
// output register stage.
//
// Handshake: rd_en is a request strobe with no back-pressure; every accepted
// request (rd_en while not busy) produces exactly one rd_valid pulse after the
// read latency (1, or 2 with OUT_REG), aligned with the new rd_data, which is
// held until the next result. Requests made while busy are ignored.
module ram_dp_param #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RDW_NEW  = 0,
  parameter int                OUT_REG  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err,
  output ram_pkg::ram_state_e dbg_state
);

  import ram_pkg::*;

  // Index width actually needed by the array; addresses above DEPTH-1 are
  // filtered by the range checks before they reach the array.
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam bit              BYPASS  = (RDW_NEW == ram_pkg::RDW_NEW);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_addr;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_word;

  logic [DATA_W-1:0] r_rd_data1;
  logic              r_rd_valid1;
  logic              r_addr_err;

  ram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .state    (dbg_state)
  );

  assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // User port is only live once the sweep has finished.
  assign w_wr_fire = !w_busy && wr_en && w_wr_in_range;
  assign w_rd_fire = !w_busy && rd_en;

  // Either port out of range gives one shared error pulse.
  assign w_err = !w_busy && ((wr_en && !w_wr_in_range) ||
                             (rd_en && !w_rd_in_range));

  // Read word selection: out-of-range reads return zero; a same-address
  // write in the same cycle is forwarded only in bypass mode.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (BYPASS && w_wr_fire && (wr_addr == rd_addr)) begin
        w_rd_word = wr_data;
      end else begin
        w_rd_word = r_mem[rd_addr[IDX_W-1:0]];
      end
    end
  end

  // Array write port: the sweep has priority over (and excludes) user writes.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= INIT_VAL;
    end else if (w_wr_fire) begin
      r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // First read stage plus the error strobe; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data1  <= '0;
      r_rd_valid1 <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_rd_valid1 <= w_rd_fire;
      r_addr_err  <= w_err;
      if (w_rd_fire) begin
        r_rd_data1 <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_rd_data2;
      logic              r_rd_valid2;

      // Optional output stage: forwards stage-one results one cycle later.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data2  <= '0;
          r_rd_valid2 <= 1'b0;
        end else begin
          r_rd_valid2 <= r_rd_valid1;
          if (r_rd_valid1) begin
            r_rd_data2 <= r_rd_data1;
          end
        end
      end

      assign rd_data  = r_rd_data2;
      assign rd_valid = r_rd_valid2;
    end else begin : g_no_out_reg
      assign rd_data  = r_rd_data1;
      assign rd_valid = r_rd_valid1;
    end
  endgenerate

  assign busy     = w_busy;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: five configurations driven from one stimulus.
//   u0: DEPTH 8, ADDR_W 4, old-data RDW, latency 1
//   u1: as u0 with the output register (latency 2)
//   u2: as u0 with new-data RDW
//   u3: DEPTH 6, ADDR_W 3 (out-of-range addresses 6, 7)
//   u4: DEPTH 8, ADDR_W 3, INIT_VAL 6 (full address space)
module tb_ram_dp_param;
  import ram_pkg::*;

  localparam int NU = 5;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic [3:0] rdat [NU];
  logic       rval [NU];
  logic       bsy  [NU];
  logic       aerr [NU];
  ram_state_e st   [NU];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp0 [8];
  logic [3:0] exp3 [8];
  logic [3:0] exp4 [8];

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [3:0] d0;    // u0/u1 data (old-data RDW)
    logic [3:0] d2;    // u2 data (new-data RDW)
    logic [3:0] d3;    // u3 data
    logic       v;     // rd_valid
    logic       err0;  // u0 addr_err
    logic       err3;  // u3 addr_err
  } vec_t;

  vec_t tbl [14];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ram_dp_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(8), .INIT_VAL(4'h0),
                 .RDW_NEW(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[0]),
    .rd_valid(rval[0]), .busy(bsy[0]), .addr_err(aerr[0]), .dbg_state(st[0]));

  ram_dp_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(8), .INIT_VAL(4'h0),
                 .RDW_NEW(0), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[1]),
    .rd_valid(rval[1]), .busy(bsy[1]), .addr_err(aerr[1]), .dbg_state(st[1]));

  ram_dp_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(8), .INIT_VAL(4'h0),
                 .RDW_NEW(1), .OUT_REG(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[2]),
    .rd_valid(rval[2]), .busy(bsy[2]), .addr_err(aerr[2]), .dbg_state(st[2]));

  ram_dp_param #(.DATA_W(4), .ADDR_W(3), .DEPTH(6), .INIT_VAL(4'h0),
                 .RDW_NEW(0), .OUT_REG(0)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr[2:0]),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .rd_data(rdat[3]),
    .rd_valid(rval[3]), .busy(bsy[3]), .addr_err(aerr[3]), .dbg_state(st[3]));

  ram_dp_param #(.DATA_W(4), .ADDR_W(3), .DEPTH(8), .INIT_VAL(4'h6),
                 .RDW_NEW(0), .OUT_REG(0)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr[2:0]),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .rd_data(rdat[4]),
    .rd_valid(rval[4]), .busy(bsy[4]), .addr_err(aerr[4]), .dbg_state(st[4]));

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
    rd_en = 1'b0; rd_addr = 4'h0;
  endtask

  // Counts rising edges until busy drops, per instance. Called just after
  // the sweep has been (re)started. For the first 'noise' edges the user
  // ports are driven and must be ignored, with rd_data holding 'hold_val'.
  task automatic sweep_count(input int noise, input logic [3:0] hold_val, input string tag);
    int nb [NU];
    bit all_done;
    for (int i = 0; i < NU; i++) nb[i] = -1;
    if (noise > 0) begin
      wr_en = 1'b1; wr_addr = 4'h1; wr_data = 4'h3;
      rd_en = 1'b1; rd_addr = 4'h7;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k <= noise) begin
        chk($sformatf("%s_sweep_rval_u0_k%0d", tag, k), 32'(rval[0]), 32'h0);
        chk($sformatf("%s_sweep_rval_u3_k%0d", tag, k), 32'(rval[3]), 32'h0);
        chk($sformatf("%s_sweep_aerr_u3_k%0d", tag, k), 32'(aerr[3]), 32'h0);
        chk($sformatf("%s_sweep_hold_u0_k%0d", tag, k), 32'(rdat[0]), 32'(hold_val));
        if (k == noise) idle_inputs();
      end
      all_done = 1'b1;
      for (int i = 0; i < NU; i++) begin
        if (nb[i] < 0 && !bsy[i]) nb[i] = k;
        if (nb[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    idle_inputs();
    chk($sformatf("%s_busy_cycles_u0", tag), 32'(nb[0]), 32'd8);
    chk($sformatf("%s_busy_cycles_u1", tag), 32'(nb[1]), 32'd8);
    chk($sformatf("%s_busy_cycles_u3", tag), 32'(nb[3]), 32'd6);
    chk($sformatf("%s_busy_cycles_u4", tag), 32'(nb[4]), 32'd8);
    chk($sformatf("%s_state_ready_u0", tag), 32'(st[0]), 32'(ST_READY));
  endtask

  // Back-to-back reads of addresses 0..7 against exp0/exp3/exp4.
  task automatic read_all(input string tag);
    for (int j = 0; j <= 8; j++) begin
      rd_en   = (j < 8);
      rd_addr = 4'(j);
      @(posedge clk); #1;
      if (j < 8) begin
        chk($sformatf("%s_rd%0d_u0", tag, j), 32'(rdat[0]), 32'(exp0[j]));
        chk($sformatf("%s_rv%0d_u0", tag, j), 32'(rval[0]), 32'h1);
        chk($sformatf("%s_rd%0d_u2", tag, j), 32'(rdat[2]), 32'(exp0[j]));
        chk($sformatf("%s_rd%0d_u3", tag, j), 32'(rdat[3]), 32'(exp3[j]));
        chk($sformatf("%s_rv%0d_u3", tag, j), 32'(rval[3]), 32'h1);
        chk($sformatf("%s_rd%0d_u4", tag, j), 32'(rdat[4]), 32'(exp4[j]));
      end else begin
        chk($sformatf("%s_rv_end_u0", tag), 32'(rval[0]), 32'h0);
      end
      if (j > 0) begin
        chk($sformatf("%s_rd%0d_u1", tag, j - 1), 32'(rdat[1]), 32'(exp0[j - 1]));
        chk($sformatf("%s_rv%0d_u1", tag, j - 1), 32'(rval[1]), 32'h1);
      end
    end
    idle_inputs();
  endtask

  task automatic set_exp(input logic [31:0] e0, input logic [31:0] e3, input logic [31:0] e4);
    for (int i = 0; i < 8; i++) begin
      exp0[i] = e0[4*i +: 4];
      exp3[i] = e3[4*i +: 4];
      exp4[i] = e4[4*i +: 4];
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    //         we  wa    wd    re  ra    d0    d2    d3    v  e0 e3
    tbl[0]  = '{0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0};
    tbl[1]  = '{1, 4'h3, 4'hA, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0};
    tbl[2]  = '{0, 4'h0, 4'h0, 1, 4'h3, 4'hA, 4'hA, 4'hA, 1, 0, 0};
    tbl[3]  = '{1, 4'h6, 4'h9, 0, 4'h0, 4'hA, 4'hA, 4'hA, 0, 0, 1};
    tbl[4]  = '{1, 4'h6, 4'h5, 1, 4'h6, 4'h9, 4'h5, 4'h0, 1, 0, 1};
    tbl[5]  = '{0, 4'h0, 4'h0, 1, 4'h6, 4'h5, 4'h5, 4'h0, 1, 0, 1};
    tbl[6]  = '{1, 4'h7, 4'hC, 1, 4'h7, 4'h0, 4'hC, 4'h0, 1, 0, 1};
    tbl[7]  = '{0, 4'h0, 4'h0, 1, 4'h7, 4'hC, 4'hC, 4'h0, 1, 0, 1};
    tbl[8]  = '{1, 4'h2, 4'h3, 1, 4'h5, 4'h0, 4'h0, 4'h0, 1, 0, 0};
    tbl[9]  = '{0, 4'h0, 4'h0, 1, 4'h2, 4'h3, 4'h3, 4'h3, 1, 0, 0};
    tbl[10] = '{0, 4'h0, 4'h0, 1, 4'h9, 4'h0, 4'h0, 4'h0, 1, 1, 0};
    tbl[11] = '{0, 4'h0, 4'h0, 1, 4'h3, 4'hA, 4'hA, 4'hA, 1, 0, 0};
    tbl[12] = '{1, 4'h3, 4'h7, 1, 4'h2, 4'h3, 4'h3, 4'h3, 1, 0, 0};
    tbl[13] = '{0, 4'h0, 4'h0, 1, 4'h3, 4'h7, 4'h7, 4'h7, 1, 0, 0};

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("rst_rd_data_u%0d", i), 32'(rdat[i]), 32'h0);
      chk($sformatf("rst_rd_valid_u%0d", i), 32'(rval[i]), 32'h0);
      chk($sformatf("rst_addr_err_u%0d", i), 32'(aerr[i]), 32'h0);
      chk($sformatf("rst_busy_u%0d", i), 32'(bsy[i]), 32'h1);
      chk($sformatf("rst_state_u%0d", i), 32'(st[i]), 32'(ST_CLEAR));
    end

    // Initial sweep and readback of the initial values.
    rst_n = 1'b1;
    sweep_count(0, 4'h0, "init");
    set_exp(32'h0000_0000, 32'h0000_0000, 32'h6666_6666);
    read_all("init");

    // Table-driven single-cycle operations, each followed by an idle cycle.
    for (int t = 0; t < 14; t++) begin
      wr_en = tbl[t].we; wr_addr = tbl[t].wa; wr_data = tbl[t].wd;
      rd_en = tbl[t].re; rd_addr = tbl[t].ra;
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("vec%0d_rd_u0", t), 32'(rdat[0]), 32'(tbl[t].d0));
      chk($sformatf("vec%0d_rv_u0", t), 32'(rval[0]), 32'(tbl[t].v));
      chk($sformatf("vec%0d_err_u0", t), 32'(aerr[0]), 32'(tbl[t].err0));
      chk($sformatf("vec%0d_rd_u2", t), 32'(rdat[2]), 32'(tbl[t].d2));
      chk($sformatf("vec%0d_rd_u3", t), 32'(rdat[3]), 32'(tbl[t].d3));
      chk($sformatf("vec%0d_rv_u3", t), 32'(rval[3]), 32'(tbl[t].v));
      chk($sformatf("vec%0d_err_u3", t), 32'(aerr[3]), 32'(tbl[t].err3));
      chk($sformatf("vec%0d_rv_u1_early", t), 32'(rval[1]), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd_u1", t), 32'(rdat[1]), 32'(tbl[t].d0));
      chk($sformatf("vec%0d_rv_u1", t), 32'(rval[1]), 32'(tbl[t].v));
      chk($sformatf("vec%0d_err_u3_once", t), 32'(aerr[3]), 32'h0);
    end

    // Back-to-back readback of the contents left by the table.
    set_exp(32'hC500_7300, 32'h0000_7300, 32'hC566_7366);
    read_all("post_tbl");

    // Reset in the middle of a read pipeline (u1 has stage one loaded).
    rd_en = 1'b1; rd_addr = 4'h3;
    @(posedge clk); #1;
    idle_inputs();
    chk("midrd_rd_u0", 32'(rdat[0]), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrd_rst_rd_u1", 32'(rdat[1]), 32'h0);
    chk("midrd_rst_rv_u1", 32'(rval[1]), 32'h0);
    chk("midrd_rst_rd_u0", 32'(rdat[0]), 32'h0);
    chk("midrd_rst_busy_u1", 32'(bsy[1]), 32'h1);
    chk("midrd_rst_state_u1", 32'(st[1]), 32'(ST_CLEAR));
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_count(0, 4'h0, "midrd");

    // Reset on sweep cycle 3.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midsw_busy_u0", 32'(bsy[0]), 32'h1);
    chk("midsw_state_u0", 32'(st[0]), 32'(ST_CLEAR));
    chk("midsw_rv_u1", 32'(rval[1]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_count(0, 4'h0, "midsw");

    // Fill with 0xF, read one entry, then clear with port activity mid-sweep.
    for (int j = 0; j < 8; j++) begin
      wr_en = 1'b1; wr_addr = 4'(j); wr_data = 4'hF;
      @(posedge clk); #1;
    end
    idle_inputs();
    rd_en = 1'b1; rd_addr = 4'h5;
    @(posedge clk); #1;
    idle_inputs();
    chk("fill_rd5_u0", 32'(rdat[0]), 32'hF);
    chk("fill_rd5_u4", 32'(rdat[4]), 32'hF);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_busy_u0", 32'(bsy[0]), 32'h1);
    chk("clr_state_u0", 32'(st[0]), 32'(ST_CLEAR));
    sweep_count(3, 4'hF, "clr");
    set_exp(32'h0000_0000, 32'h0000_0000, 32'h6666_6666);
    read_all("post_clr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised simple dual-port RAM: one write port and one registered read port, with configurable width and depth. It supersedes the fixed 4-bit/8-entry dual-input RAM used as scratch storage in the practice designs. Additions over that RAM:
- hardware clear sequencer, since an asynchronous reset of the whole array is not synthesisable as RAM;
- selectable read-during-write policy;
- optional output pipeline stage;
- read-valid strobe and address-range error flag.

Parameters:
- DATA_W, 4, data width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of entries; must be 1 to 2**ADDR_W.
- INIT_VAL, 0, value written to every entry by the clear sequencer (DATA_W bits).
- RDW_NEW, 0, same-address read-during-write result: 0 returns old data, 1 returns new data (bypass).
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register, giving latency 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to re-run the clear sweep; single-cycle pulse.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data, held between reads.
- rd_valid  out  1  one-cycle pulse, aligned with new rd_data.
- busy  out  1  high while the clear sweep runs.
- addr_err  out  1  one-cycle pulse for an out-of-range access.

Behaviour:
- Reset values (rst_n low): rd_data=0, rd_valid=0, addr_err=0, busy=1, FSM=CLEAR, sweep pointer=0.
  - Array contents are not reset directly; they are initialised by the sweep.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes INIT_VAL to mem[ptr] and increments ptr. When ptr==DEPTH-1 has been written, next state is READY and busy drops.
  - The sweep takes exactly DEPTH cycles after reset deassertion. busy is low from cycle DEPTH onward.
  - READY: clr=1 gives ptr=0 and next state CLEAR. busy is high from the next cycle.
  - clr during CLEAR restarts the sweep at 0.
- During CLEAR, wr_en and rd_en are ignored:
  - no array write from the port;
  - no rd_valid;
  - addr_err stays 0;
  - rd_data holds its value.
- Write (READY, wr_en, wr_addr<DEPTH): mem[wr_addr]<=wr_data at the clock edge.
- Read (READY, rd_en, rd_addr<DEPTH): data is sampled at the edge.
  - OUT_REG=0: rd_data and rd_valid update at the same edge as the request (one cycle later).
  - OUT_REG=1: they update one edge later.
  - Back-to-back reads give one result per cycle. rd_valid is the rd_en pipeline, delayed by the latency.
- Read-during-write, same address, same cycle:
  - RDW_NEW=0: rd_data returns the pre-write contents.
  - RDW_NEW=1: rd_data returns wr_data.
  - Different addresses: the two ports are independent.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - the write is dropped;
  - a read returns 0 with rd_valid still pulsed;
  - addr_err pulses one cycle after the offending request (read or write). Both ports offending gives a single pulse.
- rst_n asserted mid-sweep or mid-read: all outputs return to reset values immediately. The OUT_REG pipeline is flushed and the sweep restarts on deassertion.
- Width rules: ptr is ADDR_W+1 bits, so DEPTH=2**ADDR_W terminates without wrap. No arithmetic on data.

Decomposition:
- Shared package ram_pkg:
  - FSM state typedef (CLEAR, READY);
  - RDW mode constants RDW_OLD and RDW_NEW.
- One natural sub-module, ram_clr_seq: the CLEAR/READY FSM and pointer, outputting busy, clr_we and clr_addr.
- Top level: muxes the sweep port over the user write port, and holds the array, RDW logic and output pipeline.

Test Plan:
1. Reset then idle, DEPTH=8: busy high for 8 cycles, then low. Reading addresses 0..7 returns INIT_VAL=0 with rd_valid one cycle after each rd_en.
2. Write 0xA to address 3, then read address 3 the next cycle (OUT_REG=0): rd_data=0xA and rd_valid=1 one cycle later. With OUT_REG=1, the same result arrives two cycles later.
3. Same-cycle write 0x5 and read of address 6, which holds 0x9: RDW_NEW=0 gives rd_data=0x9; RDW_NEW=1 gives 0x5.
4. DEPTH=6, ADDR_W=3: write address 7 and read address 7 gives addr_err pulsing once, rd_data=0, and address 0..5 contents unchanged.
5. clr pulse after filling the array with 0xF: busy high for DEPTH cycles, a wr_en during the sweep is ignored, and all reads afterwards return INIT_VAL.
6. rst_n pulled low on sweep cycle 3 and mid read pipeline (OUT_REG=1): rd_valid=0 and rd_data=0 immediately. The sweep restarts and busy stays high for DEPTH cycles after release.
